// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port RAM (SIZE-bit word address, 32-bit data, 1-cycle
//   read latency) between M0 (CPU core) and M1 (loader/DMA).
//   Grant is decided combinationally each cycle from the requests and the
//   registered arbitration state. Priority order:
//     1. a locked owner that is still requesting keeps the port
//     2. a single requester wins
//     3. both requesting with the burst cap reached: the other master wins
//     4. both requesting: round-robin against last_gnt
//   Read data is steered back to whichever master issued the read on the
//   previous cycle.
//
// Ports
//   clk, rst                   clock, synchronous active-low reset
//   m0_req/we/lock/addr/wdata  M0 request side
//   m0_gnt, m0_rvalid, m0_rdata M0 grant and read return
//   m1_*                       identical set for M1
//   ram_we/addr/wdata          RAM command (zeroed when nothing is granted)
//   ram_rdata                  RAM read data, valid the cycle after the address
//   stats_clr, m0_gnt_cnt, m1_gnt_cnt
//                              only when RAM_ARB_STATS_EN is defined:
//                              saturating per-master grant counters
//
// Build option
//   RAM_ARB_STATS_EN  adds the grant counters and their clear input.
//
// State (owner register)
//   state     | meaning
//   OWN_NONE  | nothing was granted last cycle
//   OWN_M0    | M0 was granted last cycle (holds the port if locked)
//   OWN_M1    | M1 was granted last cycle (holds the port if locked)

module ram_port_arbiter #(
  parameter int SIZE      = 14,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic            m0_lock,
  input  logic [SIZE-1:0] m0_addr,
  input  logic [31:0]     m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [31:0]     m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic            m1_lock,
  input  logic [SIZE-1:0] m1_addr,
  input  logic [31:0]     m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [31:0]     m1_rdata,
  output logic            ram_we,
  output logic [SIZE-1:0] ram_addr,
  output logic [31:0]     ram_wdata,
  input  logic [31:0]     ram_rdata
`ifdef RAM_ARB_STATS_EN
  ,
  input  logic            stats_clr,
  output logic [31:0]     m0_gnt_cnt,
  output logic [31:0]     m1_gnt_cnt
`endif
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  owner_t          owner_q, owner_n;
  owner_t          rd_tag_q, rd_tag_n;
  logic            locked_q, locked_n;
  logic            last_gnt_q, last_gnt_n;   // 0 = M0, 1 = M1
  logic [BW-1:0]   burst_cnt_q, burst_cnt_n;

  logic            win_m0;
  logic            win_m1;
  logic            cap_hit;
  logic            sel_we;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q     <= OWN_NONE;
      rd_tag_q    <= OWN_NONE;
      locked_q    <= 1'b0;
      last_gnt_q  <= 1'b1;          // M0 wins the first tie after reset
      burst_cnt_q <= '0;
    end else begin
      owner_q     <= owner_n;
      rd_tag_q    <= rd_tag_n;
      locked_q    <= locked_n;
      last_gnt_q  <= last_gnt_n;
      burst_cnt_q <= burst_cnt_n;
    end
  end

  // ---------------------------------------------------------------------
  // Winner select and next state
  // ---------------------------------------------------------------------
  assign cap_hit = (burst_cnt_q == BURST_MAX);

  always_comb begin
    win_m0 = 1'b0;
    win_m1 = 1'b0;
    if (locked_q && (owner_q == OWN_M0) && m0_req) begin
      win_m0 = 1'b1;
    end else if (locked_q && (owner_q == OWN_M1) && m1_req) begin
      win_m1 = 1'b1;
    end else if (m0_req && !m1_req) begin
      win_m0 = 1'b1;
    end else if (m1_req && !m0_req) begin
      win_m1 = 1'b1;
    end else if (m0_req && m1_req) begin
      // With the cap reached the port must hand over; without it plain
      // round-robin also hands over, so both cases pick the non-last master.
      if (cap_hit) begin
        win_m0 = last_gnt_q;
        win_m1 = !last_gnt_q;
      end else begin
        win_m0 = last_gnt_q;
        win_m1 = !last_gnt_q;
      end
    end
    if (!rst) begin
      win_m0 = 1'b0;
      win_m1 = 1'b0;
    end
  end

  assign sel_we = win_m1 ? m1_we : m0_we;

  always_comb begin
    owner_n     = OWN_NONE;
    rd_tag_n    = OWN_NONE;
    locked_n    = 1'b0;
    last_gnt_n  = last_gnt_q;
    burst_cnt_n = '0;
    if (win_m0 || win_m1) begin
      owner_n    = win_m1 ? OWN_M1 : OWN_M0;
      rd_tag_n   = sel_we ? OWN_NONE : owner_n;
      locked_n   = win_m1 ? m1_lock : m0_lock;
      last_gnt_n = win_m1;
      if (win_m1 != last_gnt_q) begin
        burst_cnt_n = BW'(1);
      end else if (cap_hit) begin
        burst_cnt_n = burst_cnt_q;
      end else begin
        burst_cnt_n = burst_cnt_q + BW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    m0_gnt    = win_m0;
    m1_gnt    = win_m1;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (win_m0) begin
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end else if (win_m1) begin
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end
    // Gating with rst drops a read return that is in flight when reset hits.
    m0_rvalid = rst && (rd_tag_q == OWN_M0);
    m1_rvalid = rst && (rd_tag_q == OWN_M1);
    m0_rdata  = m0_rvalid ? ram_rdata : 32'h0;
    m1_rdata  = m1_rvalid ? ram_rdata : 32'h0;
  end

`ifdef RAM_ARB_STATS_EN
  // ---------------------------------------------------------------------
  // Grant statistics; clear takes precedence over a same-cycle grant
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst || stats_clr) begin
      m0_gnt_cnt <= 32'h0;
      m1_gnt_cnt <= 32'h0;
    end else begin
      if (win_m0 && (m0_gnt_cnt != 32'hFFFF_FFFF)) begin
        m0_gnt_cnt <= m0_gnt_cnt + 32'd1;
      end
      if (win_m1 && (m1_gnt_cnt != 32'hFFFF_FFFF)) begin
        m1_gnt_cnt <= m1_gnt_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  localparam int SIZE = 14;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            m0_req = 0, m0_we = 0, m0_lock = 0;
  logic [SIZE-1:0] m0_addr = '0;
  logic [31:0]     m0_wdata = '0;
  logic            m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [SIZE-1:0] m1_addr = '0;
  logic [31:0]     m1_wdata = '0;
  logic            m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]     m0_rdata, m1_rdata;
  logic            ram_we;
  logic [SIZE-1:0] ram_addr;
  logic [31:0]     ram_wdata;
  bit   [31:0]     ram_rdata;
`ifdef RAM_ARB_STATS_EN
  logic            stats_clr = 1'b0;
  logic [31:0]     m0_gnt_cnt, m1_gnt_cnt;
`endif

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.SIZE(SIZE), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef RAM_ARB_STATS_EN
    , .stats_clr(stats_clr), .m0_gnt_cnt(m0_gnt_cnt), .m1_gnt_cnt(m1_gnt_cnt)
`endif
  );

  // Behavioural single-port RAM, one-cycle read latency
  bit [31:0] mem [0:255];
  bit        preload = 1'b1;
  always @(posedge clk) begin
    if (preload) mem[5] <= 32'hDEADBEEF;
    else if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[7:0]];
  end

  typedef struct {
    logic        rst;
    logic        r0, w0, l0;
    int          a0;
    logic [31:0] d0;
    logic        r1, w1, l1;
    int          a1;
    logic [31:0] d1;
    logic        g0, g1, we;
    int          addr;
    logic [31:0] wd;
    logic        v0;
    logic [31:0] rd0;
    logic        v1;
    logic [31:0] rd1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rs,
      logic r0, logic w0, logic l0, int a0, logic [31:0] d0,
      logic r1, logic w1, logic l1, int a1, logic [31:0] d1,
      logic g0, logic g1, logic we, int addr, logic [31:0] wd,
      logic v0, logic [31:0] rd0, logic v1, logic [31:0] rd1);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.we = we; v.addr = addr; v.wd = wd;
    v.v0 = v0; v.rd0 = rd0; v.v1 = v1; v.rd1 = rd1;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    // rst  m0:req we lk addr wdata   m1:req we lk addr wdata  | g0 g1 we addr wdata | v0 rd0 v1 rd1
    // reset holds everything off even with both requesting
    vecs.push_back(mk(0, 1,0,0,'h00,0, 1,0,0,'h00,0, 0,0,0,'h00,0, 0,0,0,0));
    vecs.push_back(mk(0, 1,0,0,'h00,0, 1,0,0,'h00,0, 0,0,0,'h00,0, 0,0,0,0));
    // first cycle out of reset: M0 wins the tie
    vecs.push_back(mk(1, 1,0,0,'h01,0, 1,0,0,'h02,0, 1,0,0,'h01,0, 0,0,0,0));
    // M0 read of 0x5
    vecs.push_back(mk(1, 1,0,0,'h05,0, 0,0,0,'h00,0, 1,0,0,'h05,0, 1,0,0,0));
    vecs.push_back(mk(1, 0,0,0,'h00,0, 0,0,0,'h00,0, 0,0,0,'h00,0, 1,32'hDEADBEEF,0,0));
    // continuous contention alternates
    vecs.push_back(mk(1, 1,0,0,'h20,0, 1,0,0,'h21,0, 0,1,0,'h21,0, 0,0,0,0));
    vecs.push_back(mk(1, 1,0,0,'h20,0, 1,0,0,'h21,0, 1,0,0,'h20,0, 0,0,1,0));
    vecs.push_back(mk(1, 1,0,0,'h20,0, 1,0,0,'h21,0, 0,1,0,'h21,0, 1,0,0,0));
    vecs.push_back(mk(1, 1,0,0,'h20,0, 1,0,0,'h21,0, 1,0,0,'h20,0, 0,0,1,0));
    vecs.push_back(mk(1, 0,0,0,'h00,0, 0,0,0,'h00,0, 0,0,0,'h00,0, 1,0,0,0));
    // M0 alone three cycles, then M1 joins
    vecs.push_back(mk(1, 1,0,0,'h30,0, 0,0,0,'h00,0, 1,0,0,'h30,0, 0,0,0,0));
    vecs.push_back(mk(1, 1,0,0,'h30,0, 0,0,0,'h00,0, 1,0,0,'h30,0, 1,0,0,0));
    vecs.push_back(mk(1, 1,0,0,'h30,0, 0,0,0,'h00,0, 1,0,0,'h30,0, 1,0,0,0));
    vecs.push_back(mk(1, 1,0,0,'h30,0, 1,0,0,'h31,0, 0,1,0,'h31,0, 1,0,0,0));
    vecs.push_back(mk(1, 1,0,0,'h30,0, 1,0,0,'h31,0, 1,0,0,'h30,0, 0,0,1,0));
    vecs.push_back(mk(1, 1,0,0,'h30,0, 1,0,0,'h31,0, 0,1,0,'h31,0, 1,0,0,0));
    vecs.push_back(mk(1, 0,0,0,'h00,0, 0,0,0,'h00,0, 0,0,0,'h00,0, 0,0,1,0));
    // M0 locked six cycles beats the burst cap; M1 gets in when M0 drops req
    vecs.push_back(mk(1, 1,0,1,'h40,0, 1,0,0,'h41,0, 1,0,0,'h40,0, 0,0,0,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 1,0,1,'h40,0, 1,0,0,'h41,0, 1,0,0,'h40,0, 1,0,0,0));
    vecs.push_back(mk(1, 0,0,0,'h00,0, 1,0,0,'h41,0, 0,1,0,'h41,0, 1,0,0,0));
    vecs.push_back(mk(1, 0,0,0,'h00,0, 0,0,0,'h00,0, 0,0,0,'h00,0, 0,0,1,0));
    // M1 write then M0 read back
    vecs.push_back(mk(1, 0,0,0,'h00,0, 1,1,0,'h10,32'h1234, 0,1,1,'h10,32'h1234, 0,0,0,0));
    vecs.push_back(mk(1, 1,0,0,'h10,0, 0,0,0,'h00,0, 1,0,0,'h10,0, 0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,'h00,0, 0,0,0,'h00,0, 0,0,0,'h00,0, 1,32'h1234,0,0));
    // write grant coincides with previous read return
    vecs.push_back(mk(1, 1,0,0,'h10,0, 0,0,0,'h00,0, 1,0,0,'h10,0, 0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,'h00,0, 1,1,0,'h10,32'h55, 0,1,1,'h10,32'h55, 1,32'h1234,0,0));
    vecs.push_back(mk(1, 0,0,0,'h00,0, 0,0,0,'h00,0, 0,0,0,'h00,0, 0,0,0,0));
    // reset mid-read drops rvalid and restores M0-first tie break
    vecs.push_back(mk(1, 1,0,0,'h05,0, 0,0,0,'h00,0, 1,0,0,'h05,0, 0,0,0,0));
    vecs.push_back(mk(0, 0,0,0,'h00,0, 1,0,0,'h07,0, 0,0,0,'h00,0, 0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,'h00,0, 0,0,0,'h00,0, 0,0,0,'h00,0, 0,0,0,0));
    vecs.push_back(mk(1, 1,0,0,'h05,0, 1,0,0,'h06,0, 1,0,0,'h05,0, 0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,'h00,0, 0,0,0,'h00,0, 0,0,0,'h00,0, 1,32'hDEADBEEF,0,0));

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      preload  = 1'b0;
      rst      = vecs[i].rst;
      m0_req   = vecs[i].r0; m0_we = vecs[i].w0; m0_lock = vecs[i].l0;
      m0_addr  = SIZE'(vecs[i].a0); m0_wdata = vecs[i].d0;
      m1_req   = vecs[i].r1; m1_we = vecs[i].w1; m1_lock = vecs[i].l1;
      m1_addr  = SIZE'(vecs[i].a1); m1_wdata = vecs[i].d1;
      @(negedge clk);
      applied++;
      chk("m0_gnt",    i, 32'(m0_gnt),    32'(vecs[i].g0));
      chk("m1_gnt",    i, 32'(m1_gnt),    32'(vecs[i].g1));
      chk("ram_we",    i, 32'(ram_we),    32'(vecs[i].we));
      chk("ram_addr",  i, 32'(ram_addr),  32'(vecs[i].addr));
      chk("ram_wdata", i, ram_wdata,      vecs[i].wd);
      chk("m0_rvalid", i, 32'(m0_rvalid), 32'(vecs[i].v0));
      chk("m0_rdata",  i, m0_rdata,       vecs[i].rd0);
      chk("m1_rvalid", i, 32'(m1_rvalid), 32'(vecs[i].v1));
      chk("m1_rdata",  i, m1_rdata,       vecs[i].rd1);
    end

`ifdef RAM_ARB_STATS_EN
    // Counters restarted at the mid-test reset; one M0 grant since then.
    applied++;
    chk("m0_gnt_cnt", 900, m0_gnt_cnt, 32'd1);
    chk("m1_gnt_cnt", 900, m1_gnt_cnt, 32'd0);
    @(posedge clk); #1;
    m0_req = 0; m1_req = 1; m1_we = 1; m1_addr = SIZE'(8); m1_wdata = 32'h9;
    @(posedge clk); #1;
    m1_req = 0; m1_we = 0;
    @(negedge clk);
    applied++;
    chk("m0_gnt_cnt", 901, m0_gnt_cnt, 32'd1);
    chk("m1_gnt_cnt", 901, m1_gnt_cnt, 32'd1);
    // clear beats a same-cycle grant
    @(posedge clk); #1;
    stats_clr = 1; m0_req = 1;
    @(posedge clk); #1;
    stats_clr = 0; m0_req = 0;
    @(negedge clk);
    applied++;
    chk("m0_gnt_cnt", 902, m0_gnt_cnt, 32'd0);
    chk("m1_gnt_cnt", 902, m1_gnt_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
